mac_pipe_acc: RTL and testbench

- Parametrised, pipelined, multi-lane signed multiply-accumulate block.
- Each lane computes either R = A*B + C (load) or R += A*B + C (accumulate).
- Adds optional operand approximation, saturation, overflow flags and valid/ready handshaking.
- Sits between a probe/stimulus source (VIO or stream master) and result capture logic; replaces fixed 16-bit single-shot MAC instances.

---
 rtl/mac_pkg.sv | 45 ++++
 rtl/mac_lane.sv | 106 ++++++++++
 rtl/mac_pipe_acc.sv | 120 ++++++++++++
 tb/tb_mac_pipe_acc.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and arithmetic helpers for the pipelined MAC block.
package mac_pkg;

    // Accumulate-mode encoding carried alongside each beat.
    localparam logic ACC_LOAD  = 1'b0;
    localparam logic ACC_ACCUM = 1'b1;

    // Internal arithmetic width; wide enough that acc + product + addend never
    // overflows before the ACC_W range check is applied.
    localparam int unsigned CALC_W = 128;

    typedef logic signed [CALC_W-1:0] calc_t;

    // Largest signed value representable in acc_w bits.
    function automatic calc_t acc_max(input int unsigned acc_w);
        return (calc_t'(1) <<< (acc_w - 1)) - calc_t'(1);
    endfunction

    // Smallest signed value representable in acc_w bits.
    function automatic calc_t acc_min(input int unsigned acc_w);
        return -(calc_t'(1) <<< (acc_w - 1));
    endfunction

    // Adds two sign-extended operands and fits the sum into acc_w bits,
    // clamping (sat=1) or wrapping (sat=0). Returns {ovf, sum}.
    function automatic logic [CALC_W:0] sat_add(input calc_t a, input calc_t b,
                                                input int unsigned acc_w, input logic sat);
        calc_t sum;
        calc_t res;
        logic  hi;
        logic  lo;
        sum = a + b;
        hi  = sum > acc_max(acc_w);
        lo  = sum < acc_min(acc_w);
        if (!(hi || lo)) begin
            res = sum;
        end else if (sat) begin
            res = hi ? acc_max(acc_w) : acc_min(acc_w);
        end else begin
            res = (sum <<< (CALC_W - acc_w)) >>> (CALC_W - acc_w);
        end
        return {hi || lo, res};
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: S1 operand capture with approximation mask, S2 signed multiply,
// S3 accumulate with saturation/overflow, plus the lane's output register.
module mac_lane
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACC_W       = 40,
    parameter int unsigned APPROX_BITS = 0,
    parameter int unsigned SAT         = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              s2_valid,
    input  logic              s2_acc,
    input  logic              s3_out,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    output logic [ACC_W-1:0]  out_r,
    output logic              out_ovf
);

    localparam logic [DATA_W-1:0] APPROX_MASK = {DATA_W{1'b1}} << APPROX_BITS;

    logic signed [DATA_W-1:0]   a1_q, a1_d;
    logic signed [DATA_W-1:0]   b1_q, b1_d;
    logic signed [DATA_W-1:0]   c1_q, c1_d;
    logic signed [2*DATA_W-1:0] prod2_q, prod2_d;
    logic signed [DATA_W-1:0]   c2_q, c2_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       ovf_q, ovf_d;
    logic [ACC_W-1:0]           out_r_q, out_r_d;
    logic                       out_ovf_q, out_ovf_d;

    calc_t                      base;
    calc_t                      addend;
    logic [CALC_W:0]            sum_ext;
    logic                       sat_unused_hi;

    // S1/S2 datapath: operands and product move only when the pipe advances.
    always_comb begin
        a1_d    = a1_q;
        b1_d    = b1_q;
        c1_d    = c1_q;
        prod2_d = prod2_q;
        c2_d    = c2_q;
        if (adv) begin
            a1_d    = in_a & APPROX_MASK;
            b1_d    = in_b & APPROX_MASK;
            c1_d    = in_c;
            prod2_d = a1_q * b1_q;
            c2_d    = c1_q;
        end
    end

    // S3 accumulate and output capture; stall holds the accumulator so no beat is counted twice.
    always_comb begin
        addend        = calc_t'(prod2_q) + calc_t'(c2_q);
        base          = (s2_acc == ACC_ACCUM) ? calc_t'(acc_q) : '0;
        sum_ext       = sat_add(base, addend, ACC_W, SAT != 0);
        // Bits above ACC_W are only sign extension of the fitted result.
        sat_unused_hi = ^sum_ext[CALC_W-1:ACC_W];
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        out_r_d       = out_r_q;
        out_ovf_d     = out_ovf_q;
        if (adv && s2_valid) begin
            acc_d = sum_ext[ACC_W-1:0];
            ovf_d = sum_ext[CALC_W] | ((s2_acc == ACC_ACCUM) & ovf_q);
        end
        if (adv && s3_out) begin
            out_r_d   = acc_q;
            out_ovf_d = ovf_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q      <= '0;
            b1_q      <= '0;
            c1_q      <= '0;
            prod2_q   <= '0;
            c2_q      <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            out_r_q   <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            a1_q      <= a1_d;
            b1_q      <= b1_d;
            c1_q      <= c1_d;
            prod2_q   <= prod2_d;
            c2_q      <= c2_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            out_r_q   <= out_r_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_r   = out_r_q;
    assign out_ovf = out_ovf_q;

endmodule

// File: rtl/mac_pipe_acc.sv
// Multi-lane pipelined signed MAC: shared stage control and handshake, LANES datapaths.
module mac_pipe_acc
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ACC_W       = 40,
    parameter int unsigned LANES       = 2,
    parameter int unsigned APPROX_BITS = 0,
    parameter int unsigned SAT         = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    input  logic [LANES*DATA_W-1:0] in_c,
    input  logic                    in_acc,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACC_W-1:0]  out_r,
    output logic [LANES-1:0]        out_ovf
);

    if (ACC_W < 2 * DATA_W || ACC_W >= CALC_W) begin : g_bad_acc_w
        $error("mac_pipe_acc: ACC_W must be >= 2*DATA_W and < CALC_W");
    end
    if (APPROX_BITS >= DATA_W) begin : g_bad_approx
        $error("mac_pipe_acc: APPROX_BITS must be < DATA_W");
    end

    logic adv;
    logic s1_valid_q, s1_valid_d;
    logic s1_last_q,  s1_last_d;
    logic s1_acc_q,   s1_acc_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_last_q,  s2_last_d;
    logic s2_acc_q,   s2_acc_d;
    logic s3_valid_q, s3_valid_d;
    logic s3_last_q,  s3_last_d;
    logic out_valid_q, out_valid_d;

    // The whole pipe moves unless a held result is waiting on downstream.
    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = adv;

    // Stage control shift: valid/last/acc travel with each beat.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_acc_d    = s1_acc_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        s2_acc_d    = s2_acc_q;
        s3_valid_d  = s3_valid_q;
        s3_last_d   = s3_last_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            s1_last_d   = in_last;
            s1_acc_d    = in_acc;
            s2_valid_d  = s1_valid_q;
            s2_last_d   = s1_last_q;
            s2_acc_d    = s1_acc_q;
            s3_valid_d  = s2_valid_q;
            s3_last_d   = s2_last_q;
            out_valid_d = s3_valid_q && s3_last_q;
        end
    end

    // Control registers; reset discards every in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_acc_q    <= ACC_LOAD;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_acc_q    <= ACC_LOAD;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_acc_q    <= s1_acc_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_acc_q    <= s2_acc_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(
            .DATA_W     (DATA_W),
            .ACC_W      (ACC_W),
            .APPROX_BITS(APPROX_BITS),
            .SAT        (SAT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv),
            .s2_valid(s2_valid_q),
            .s2_acc  (s2_acc_q),
            .s3_out  (s3_valid_q && s3_last_q),
            .in_a    (in_a[l*DATA_W +: DATA_W]),
            .in_b    (in_b[l*DATA_W +: DATA_W]),
            .in_c    (in_c[l*DATA_W +: DATA_W]),
            .out_r   (out_r[l*ACC_W +: ACC_W]),
            .out_ovf (out_ovf[l])
        );
    end

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Self-checking bench: three configurations driven in lockstep against a beat-level model.
module tb_mac_pipe_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] in_c = '0;
    logic        in_acc = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [79:0] out_r0;
    logic [63:0] out_r1;
    logic [79:0] out_r2;
    logic [1:0]  out_ovf0, out_ovf1, out_ovf2;

    always #5 clk = ~clk;

    mac_pipe_acc #(.DATA_W(16), .ACC_W(40), .LANES(2), .APPROX_BITS(0), .SAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_r(out_r0), .out_ovf(out_ovf0));

    mac_pipe_acc #(.DATA_W(16), .ACC_W(32), .LANES(2), .APPROX_BITS(0), .SAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_r(out_r1), .out_ovf(out_ovf1));

    mac_pipe_acc #(.DATA_W(16), .ACC_W(40), .LANES(2), .APPROX_BITS(4), .SAT(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_r(out_r2), .out_ovf(out_ovf2));

    int unsigned cfg_w   [3] = '{40, 32, 40};
    int unsigned cfg_apx [3] = '{0, 0, 4};

    typedef struct packed {
        logic [5:0]       ovf;
        logic [5:0][63:0] r;
    } res_t;

    longint      m_acc [6];
    bit          m_ovf [6];
    res_t        exp_q [$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned n_out = 0;
    bit          stall_seen = 0;
    bit          rnd_on = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int unsigned w);
        longint t;
        t = longint'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    function automatic longint get_r(input int unsigned c, input int unsigned l);
        case (c)
            0:       return sx(64'(out_r0[l*40 +: 40]), 40);
            1:       return sx(64'(out_r1[l*32 +: 32]), 32);
            default: return sx(64'(out_r2[l*40 +: 40]), 40);
        endcase
    endfunction

    function automatic longint get_ovf(input int unsigned c, input int unsigned l);
        case (c)
            0:       return longint'(out_ovf0[l]);
            1:       return longint'(out_ovf1[l]);
            default: return longint'(out_ovf2[l]);
        endcase
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 6; k++) begin
            m_acc[k] = 0;
            m_ovf[k] = 0;
        end
        exp_q.delete();
    endtask

    // Beat-level reference: masked product plus addend, onto 0 or the running sum, clamped.
    task automatic m_beat();
        res_t   e;
        longint a, b, c, msk, s, hi, lo;
        bit     o;
        for (int cf = 0; cf < 3; cf++) begin
            for (int l = 0; l < 2; l++) begin
                a   = sx(64'(in_a[l*16 +: 16]), 16);
                b   = sx(64'(in_b[l*16 +: 16]), 16);
                c   = sx(64'(in_c[l*16 +: 16]), 16);
                msk = ~((longint'(1) << cfg_apx[cf]) - 1);
                s   = (in_acc ? m_acc[cf*2+l] : 0) + (a & msk) * (b & msk) + c;
                hi  = (longint'(1) << (cfg_w[cf] - 1)) - 1;
                lo  = -hi - 1;
                o   = (s > hi) || (s < lo);
                if (s > hi) s = hi;
                if (s < lo) s = lo;
                m_acc[cf*2+l] = s;
                m_ovf[cf*2+l] = (in_acc ? m_ovf[cf*2+l] : 1'b0) | o;
                e.r[cf*2+l]   = s;
                e.ovf[cf*2+l] = m_ovf[cf*2+l];
            end
        end
        if (in_last) exp_q.push_back(e);
    endtask

    task automatic mon_step();
        res_t e;
        if (rst) begin
            m_reset();
            return;
        end
        chk("in_ready0", longint'(in_ready0), longint'(!(out_valid0 && !out_ready)));
        chk("in_ready1", longint'(in_ready1), longint'(!(out_valid1 && !out_ready)));
        chk("in_ready2", longint'(in_ready2), longint'(!(out_valid2 && !out_ready)));
        if (!in_ready0) stall_seen = 1;
        if (out_valid0 && out_ready) begin
            chk("out_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_out++;
                chk("out_valid1", longint'(out_valid1), 1);
                chk("out_valid2", longint'(out_valid2), 1);
                for (int cf = 0; cf < 3; cf++) begin
                    for (int l = 0; l < 2; l++) begin
                        chk($sformatf("r_c%0d_l%0d", cf, l), get_r(cf, l), longint'(e.r[cf*2+l]));
                        chk($sformatf("ovf_c%0d_l%0d", cf, l), get_ovf(cf, l), longint'(e.ovf[cf*2+l]));
                    end
                end
            end
        end
        if (in_valid && in_ready0) m_beat();
    endtask

    task automatic send(input logic [15:0] a0, input logic [15:0] b0, input logic [15:0] c0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic [15:0] c1,
                        input logic acc, input logic last);
        in_a     = {a1, a0};
        in_b     = {b1, b0};
        in_c     = {c1, c0};
        in_acc   = acc;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready0) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned i;
        i = 0;
        while ((exp_q.size() != 0 || out_valid0) && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("drain_timeout", longint'(i < 200), 1);
    endtask

    task automatic chk_cleared(input string tag);
        for (int cf = 0; cf < 3; cf++) begin
            for (int l = 0; l < 2; l++) begin
                chk($sformatf("%s_r_c%0d_l%0d", tag, cf, l), get_r(cf, l), 0);
                chk($sformatf("%s_ovf_c%0d_l%0d", tag, cf, l), get_ovf(cf, l), 0);
            end
        end
        chk({tag, "_ov"}, longint'({out_valid2, out_valid1, out_valid0}), 0);
        chk({tag, "_ir"}, longint'({in_ready2, in_ready1, in_ready0}), 7);
    endtask

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int unsigned n0;
        fork
            forever @(negedge clk) mon_step();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cleared("reset");

        // Single load beat: latency and lane values.
        send(16'd3, 16'd4, 16'd5, -16'sd2, 16'd7, 16'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("latency_e%0d", i), longint'(out_valid0), longint'(i == 3));
        end
        drain();
        chk("t1_lane0", get_r(0, 0), 17);
        chk("t1_lane1", get_r(0, 1), -14);
        chk("t1_ovf", longint'(out_ovf0), 0);

        // Segment of four beats, result only on the last.
        send(16'd1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd0, 1'b0, 1'b0);
        send(16'd2, 16'd2, 16'd0, 16'd2, 16'd2, 16'd0, 1'b1, 1'b0);
        send(16'd3, 16'd3, 16'd0, 16'd3, 16'd3, 16'd0, 1'b1, 1'b0);
        send(16'd4, 16'd4, 16'd10, 16'd4, 16'd4, 16'd10, 1'b1, 1'b1);
        drain();
        chk("t2_lane0", get_r(0, 0), 40);

        // Most negative operands.
        send(16'h8000, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 1'b0, 1'b1);
        drain();
        chk("t3_lane0", get_r(0, 0), 1073741823);
        chk("t3_ovf", longint'(out_ovf0), 0);

        // Saturation on the 32-bit accumulator, then ovf clears on load.
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
        drain();
        chk("t4_sat", get_r(1, 0), 2147483647);
        chk("t4_ovf", get_ovf(1, 0), 1);
        send(16'd1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd0, 1'b0, 1'b1);
        drain();
        chk("t4_reload", get_r(1, 0), 1);
        chk("t4_ovf_clr", get_ovf(1, 0), 0);

        // Continuous stream with a downstream stall.
        stall_seen = 0;
        n0 = n_out;
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(16'(i), 16'd1, 16'd0, 16'(i), 16'd1, 16'd0, 1'b0, 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t5_stall_seen", longint'(stall_seen), 1);
        chk("t5_count", longint'(n_out - n0), 8);

        // Approximation, then reset in the middle of a segment.
        send(16'h0013, 16'h0011, 16'd0, 16'h0013, 16'h0011, 16'd0, 1'b0, 1'b1);
        drain();
        chk("t6_approx", get_r(2, 0), 256);
        send(16'd5, 16'd5, 16'd0, 16'd5, 16'd5, 16'd0, 1'b0, 1'b0);
        send(16'd5, 16'd5, 16'd0, 16'd5, 16'd5, 16'd0, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cleared("midrst");
        send(16'd2, 16'd3, 16'd0, 16'd2, 16'd3, 16'd0, 1'b1, 1'b1);
        drain();
        chk("t6_after_rst", get_r(0, 0), 6);

        // Randomized traffic with random back-pressure and bubbles.
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 9) < 8)
                        send(rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op(),
                             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
                    else begin
                        @(posedge clk);
                        #1;
                    end
                end
                send(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b1, 1'b1);
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("rnd_queue_empty", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
